// File: rtl/data_memory_bank.sv
// Parametrised single-port data memory with a post-reset pattern init engine,
// registered reads with a valid strobe, write-first forwarding and optional range checking.
module data_memory_bank #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ALIAS      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  mem_write,
    input  logic                  mem_read,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  ready,
    output logic                  addr_error
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HALF  = DEPTH / 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IDX_W-1:0]      init_ptr;
    logic [DATA_WIDTH-1:0] mems [DEPTH];

    logic [IDX_W-1:0]      idx_c;
    logic                  in_range_c;
    logic                  init_we_c;
    logic                  init_last_c;
    logic                  acc_c;
    logic                  ready_c;
    logic [DATA_WIDTH-1:0] pattern_c;
    logic [DATA_WIDTH-1:0] rd_next_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: leave INIT once the last word has been written
    always_comb begin
        state_d = state_q;
        if (state_q == INIT && init_last_c) begin
            state_d = RUN;
        end
    end

    // Control decode and next values for the registered outputs
    always_comb begin
        idx_c       = address[IDX_W-1:0];
        in_range_c  = (ALIAS != 0) || ({1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH));
        init_we_c   = (state_q == INIT);
        init_last_c = (init_ptr == IDX_W'(DEPTH - 1));
        acc_c       = (state_q == RUN);
        ready_c     = (state_d == RUN);
        pattern_c   = DATA_WIDTH'(init_ptr);
        if (init_ptr >= IDX_W'(HALF)) begin
            pattern_c = DATA_WIDTH'(0) - DATA_WIDTH'(init_ptr - IDX_W'(HALF));
        end
        rd_next_c = mems[idx_c];
        if (!in_range_c) begin
            rd_next_c = '0;
        end else if (mem_write) begin
            rd_next_c = write_data;
        end
    end

    // Registered outputs and init pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            init_ptr   <= '0;
            ready      <= 1'b0;
            read_valid <= 1'b0;
            read_data  <= '0;
            addr_error <= 1'b0;
        end else begin
            if (init_we_c) begin
                init_ptr <= init_ptr + IDX_W'(1);
            end
            ready      <= ready_c;
            read_valid <= acc_c && mem_read;
            addr_error <= acc_c && (mem_read || mem_write) && !in_range_c;
            if (acc_c && mem_read) begin
                read_data <= rd_next_c;
            end
        end
    end

    // Storage array; reset itself never touches contents
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_we_c) begin
                mems[init_ptr] <= pattern_c;
            end else if (acc_c && mem_write && in_range_c) begin
                mems[idx_c] <= write_data;
            end
        end
    end

endmodule
